// File: rtl/rca_pipe.sv
// Segmented ripple-carry adder: each stage adds one SEG-bit slice using the carry registered by the previous stage.
// Latency: WIDTH/SEG cycles from acceptance to out_valid; one beat per cycle sustained.
// Backpressure: per-stage valid/ready with bubble collapse; in_ready drops only when every stage is full.
// Optional subtract mode: define RCA_PIPE_SUB_EN to add port sub (sub=1 gives A + ~B + 1, cin ignored).
module rca_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
`ifdef RCA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    // Refuse geometries where the operand cannot be split into whole segments.
    generate
        if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_cfg
            $error("rca_pipe: WIDTH must be a positive multiple of SEG");
        end
    endgenerate

    // Per-stage state: valid, operands travelling with the beat, partial sum, segment carry.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;

    // Upstream view of each stage (stage 0 sees the input port).
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_c;
    logic [WIDTH-1:0]  up_a [STAGES];
    logic [WIDTH-1:0]  up_b [STAGES];
    logic [WIDTH-1:0]  up_s [STAGES];

    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  b_in;
    logic              c_in;

`ifdef RCA_PIPE_SUB_EN
    // Subtract is folded into the operand before stage 0 so the pipeline itself stays add-only.
    assign b_in = sub ? ~B : B;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = B;
    assign c_in = cin;
`endif

    // Ready ripples back from the output: a stage can take a beat if it is empty or its successor can.
    always_comb begin
        logic chain;
        chain = out_ready;
        rdy   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = !v_q[k] || chain;
            rdy[k] = chain;
        end
    end

    // Reset also blocks acceptance so no beat is taken while rst_n is low.
    assign in_ready = rdy[0] & rst_n;

    // Route each stage's upstream source: input port for stage 0, previous stage otherwise.
    always_comb begin
        up_v[0] = in_valid;
        up_c[0] = c_in;
        up_a[0] = A;
        up_b[0] = b_in;
        up_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v_q[k-1];
            up_c[k] = c_q[k-1];
            up_a[k] = a_q[k-1];
            up_b[k] = b_q[k-1];
            up_s[k] = s_q[k-1];
        end
    end

    // Stage k adds slice k and inserts it into the skewed partial sum; overflow is formed in the last stage.
    always_comb begin
        logic [SEG:0] seg;
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            c_d[k] = c_q[k];
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
            seg = {1'b0, up_a[k][k*SEG +: SEG]} + {1'b0, up_b[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, up_c[k]};
            if (rdy[k]) begin
                v_d[k] = up_v[k];
                c_d[k] = seg[SEG];
                a_d[k] = up_a[k];
                b_d[k] = up_b[k];
                s_d[k] = up_s[k];
                s_d[k][k*SEG +: SEG] = seg[SEG-1:0];
                if (k == STAGES - 1) begin
                    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
                    ovf_d = up_a[k][WIDTH-1] ^ up_b[k][WIDTH-1] ^ seg[SEG-1] ^ seg[SEG];
                end
            end
        end
    end

    // Pipeline registers; reset discards every in-flight beat immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: doc/rca_pipe.md
RCA_PIPE -- requirements
Module: rca_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter SEG, default 8: bits added per pipeline stage. STAGES = WIDTH/SEG.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat presented.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 sub  input  1  subtract mode (present only with RCA_PIPE_SUB_EN).
REQ-011 out_valid  output  1  result beat presented.
REQ-012 out_ready  input  1  consumer accepts the result beat this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of the MSB.
REQ-015 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-016 The block SHALL compute {cout,sum} = A + B + cin, modulo 2^(WIDTH+1).
REQ-017 The block SHALL contain STAGES register stages; stage k SHALL add bit segment k (bits k*SEG .. k*SEG+SEG-1), using the carry registered by stage k-1 (cin for k=0).
REQ-018 Operand segments not yet consumed SHALL travel with the beat; completed sum segments SHALL be carried forward, skewed, so that stage STAGES-1 holds the full result.
REQ-019 A beat SHALL transfer on any edge where valid and ready are both high; no other edge transfers it.
REQ-020 Each stage k SHALL hold a valid bit v_k, with ready_k = !v_k || ready_(k+1) and ready_STAGES = out_ready; in_ready = ready_0.
REQ-021 A stage SHALL load from upstream when ready_k is high. It SHALL clear v_k when ready_k is high and upstream is not valid. Otherwise it SHALL hold its contents.
REQ-022 Latency: an accepted beat SHALL appear on out_valid exactly STAGES cycles after acceptance when out_ready is held high.
REQ-023 Throughput: one beat per cycle SHALL be sustained with out_ready high; in_ready SHALL then stay high.
REQ-024 Under backpressure (out_ready low), sum/cout/ovf SHALL remain stable while out_valid is high.
REQ-025 Under backpressure, empty stages SHALL continue to fill (bubble collapse); in_ready SHALL fall only when all STAGES stages are valid.
REQ-026 When the pipeline is full and out_ready rises, acceptance of a new beat in the same cycle SHALL be permitted; no beat is lost or duplicated.
REQ-027 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-028 Beat order at the output SHALL equal acceptance order.
REQ-029 WIDTH not a positive multiple of SEG SHALL be rejected at elaboration. SEG = WIDTH (STAGES = 1) SHALL be legal.

Reset
REQ-030 While rst_n is low: all v_k = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. in_ready SHALL be 1 once rst_n is high.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats immediately, without waiting for a clock edge.
REQ-032 No beat SHALL be accepted on the first edge while rst_n is low.

Configuration
REQ-033 With macro RCA_PIPE_SUB_EN defined, port sub SHALL exist. sub is sampled with the beat; sub=1 computes A + ~B + 1, and cin is ignored.
REQ-034 With RCA_PIPE_SUB_EN defined, cout SHALL be the raw carry-out (1 = no borrow).
REQ-035 Without RCA_PIPE_SUB_EN, port sub SHALL be absent and behaviour SHALL be the add-only behaviour of REQ-016.

Verification (WIDTH=32, SEG=8)
REQ-036 Cover: A=0xFFFFFFFF, B=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-037 Cover: A=0x7FFFFFFF, B=1, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also A=0x000000FF, B=0, cin=1 -> sum=0x00000100, exercising carry across stage 0 to stage 1.
REQ-038 Cover: 10 back-to-back beats A=i, B=i, out_ready=1 -> results 2i in order, with in_ready constantly 1 and one result per cycle.
REQ-039 Cover: out_ready=0 while driving beats each cycle -> in_ready falls after 4 accepted beats and output stays stable. Then out_ready=1 -> all 4 drain in order, plus a same-cycle new acceptance.
REQ-040 Cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, and no stale result appears after release.
REQ-041 Cover (RCA_PIPE_SUB_EN): sub=1, A=5, B=7 -> sum=0xFFFFFFFE, cout=0. Also sub=1, A=7, B=5 -> sum=2, cout=1.
